// File: rtl/ram_req_pipe.sv
// Single-port read-first RAM endpoint with request/ready acceptance, byte-lane write masking and
// a credit-bounded response path: LATENCY-1 register stages feeding a LATENCY+1 deep response FIFO.
module ram_req_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] masking,
  output logic                ready,
  output logic                valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   read_data
);

  localparam int LANES  = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int FIFO_D = LATENCY + 1;
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int CNT_W  = $clog2(FIFO_D + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  outstanding;

  logic              push_v;
  logic              push_w;
  logic [DATA_W-1:0] push_d;

  logic [DATA_W-1:0] fifo_d [FIFO_D];
  logic              fifo_w [FIFO_D];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover pipeline plus FIFO, so the FIFO can never be pushed while full.
  assign ready  = !rst && (outstanding < CNT_W'(FIFO_D));
  assign accept = req && ready;
  assign valid  = (count != '0);
  assign pop    = valid && rsp_ready;

  // Memory is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && w_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (masking[i]) mem[addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign push_v = accept;
      assign push_w = w_en;
      assign push_d = mem[addr];
    end else begin : g_pipe
      logic [LATENCY-2:0]             sv;
      logic [LATENCY-2:0]             sw;
      logic [LATENCY-2:0][DATA_W-1:0] sd;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sv <= '0;
          sw <= '0;
          sd <= '0;
        end else begin
          sv[0] <= accept;
          sw[0] <= w_en;
          sd[0] <= mem[addr];
          for (int i = 1; i < LATENCY - 1; i++) begin
            sv[i] <= sv[i-1];
            sw[i] <= sw[i-1];
            sd[i] <= sd[i-1];
          end
        end
      end

      assign push_v = sv[LATENCY-2];
      assign push_w = sw[LATENCY-2];
      assign push_d = sd[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push_v) begin
      fifo_d[tail] <= push_d;
      fifo_w[tail] <= push_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_v) tail <= ptr_inc(tail);
      if (pop)    head <= ptr_inc(head);
      unique case ({push_v, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Outputs are forced to zero when empty so stale FIFO slots never leak out.
  assign read_data = valid ? fifo_d[head] : '0;
  assign rsp_write = valid && fifo_w[head];

endmodule

// File: doc/ram_req_pipe.md
# ram_req_pipe

Parameterised, pipelined single-port RAM with a request/ready and valid/rsp_ready handshake, byte-lane write masking and bounded outstanding requests. It is the next-generation memory endpoint for the RV32I core's instruction and data ports. It replaces the fixed 32-bit, 256-word, single-cycle, no-backpressure wrapper. Width, depth and read latency are set per instance, and the core may stall response consumption without losing data.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 8: word-address width; depth = 2**ADDR_W words.
- LATENCY, 1: acceptance-to-response latency in cycles; legal range 1..4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- req  in  1  request present.
- w_en  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  word address.
- write_data  in  DATA_W  write word.
- masking  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- ready  out  1  request can be accepted this cycle.
- valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_write  out  1  response belongs to a write.
- read_data  out  DATA_W  response word.

## Operation
- A request is accepted when req=1 and ready=1 at a rising edge. Otherwise req and its operands are ignored.
- Memory is read-first:
  - On acceptance, the addressed word is read before it is modified.
  - For a write, only lanes with masking[i]=1 take write_data at the same edge.
  - masking=0 with w_en=1 is a legal no-op write that still produces a response.
- Every accepted request, read or write, produces exactly one response, in acceptance order:
  - read_data is the pre-write word at addr.
  - rsp_write equals the accepted w_en.
- Response path:
  - The read result and its write flag travel through LATENCY-1 pipeline stages.
  - They then enter a response FIFO of depth LATENCY+1.
  - valid = FIFO not empty. read_data and rsp_write are driven from the FIFO head.
  - The head is popped when valid=1 and rsp_ready=1.
- Credit counter `outstanding` (0..LATENCY+1) counts accepted requests whose responses have not yet been popped:
  - It increments on accept and decrements on pop.
  - Accept and pop in the same cycle leave it unchanged.
  - ready = (outstanding < LATENCY+1) and not in reset. ready is a combinational function of registered state only; it never depends on req.
- The credit limit guarantees the FIFO never overflows. A design that can overflow or drop a response is non-compliant.
- Response ordering is strict FIFO; there is no bypass or reordering.
- Memory contents are not cleared by rst. Their simulation value before the first write is X.

## Timing
- Reset values: ready=0 while rst=1, then 1 in the first cycle after rst deasserts; valid=0, rsp_write=0, read_data=0; outstanding=0; pipeline and FIFO empty.
- Latency: a request accepted at edge E has valid=1 from edge E+LATENCY-1, provided the FIFO ahead of it is empty.
  - LATENCY=1 reproduces the legacy behaviour: valid rises at the accepting edge.
- Throughput: with rsp_ready held at 1, one request is accepted every cycle indefinitely. ready never drops.
- Backpressure: with rsp_ready=0, exactly LATENCY+1 requests are accepted, then ready=0. ready returns to 1 in the cycle after the first pop.
- Hazard: a write accepted at edge E is visible to a read accepted at edge E+1. A read accepted at the same edge as the write cannot occur, because the RAM is single-port.
- Boundary conditions:
  - addr wraps naturally; the maximum address 2**ADDR_W-1 is legal.
  - If rst asserts mid-operation, all in-flight responses are discarded immediately and asynchronously: valid=0, outstanding=0. A write that completed its accepting edge before reset stays in memory.
- valid, once high, stays high with read_data and rsp_write stable until popped.

## Test plan
- Reset: assert rst mid-burst with 3 responses queued (LATENCY=2) -> valid=0 and ready=0 immediately; after deassert ready=1, no stale response ever appears.
- Masked write: write 0xAABBCCDD to addr 0x10 with masking=4'b1111, then write 0x11223344 with masking=4'b0101, then read 0x10 -> read response 0xAA22CC44; the second write's response returns 0xAABBCCDD with rsp_write=1.
- Latency sweep: LATENCY=1,2,4 with a single read accepted at edge E -> valid first high at E, E+1, E+3 respectively.
- Streaming: LATENCY=3, rsp_ready=1, 256 back-to-back reads of addresses 0..255 (ADDR_W=8, wrap at 255->0) -> ready constant 1, 256 responses in order, no gaps after the first.
- Backpressure: LATENCY=2, rsp_ready=0, req held high -> exactly 3 accepts, then ready=0. Raising rsp_ready for one cycle pops one response and permits one further accept; ordering is preserved.
- Simultaneous accept and pop with outstanding=LATENCY+1-1 -> outstanding unchanged, ready stays 1.
